// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational ALU among NREQ requesters.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (lowest asserted index wins, no rotating pointer).
module alu_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*WIDTH-1:0]  src1_i,
  input  logic [NREQ*WIDTH-1:0]  src2_i,
  input  logic [NREQ*CTRL_W-1:0] ctrl_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic [WIDTH-1:0]       result_o,
  output logic                   zero_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       alu_src1_o,
  output logic [WIDTH-1:0]       alu_src2_o,
  output logic [CTRL_W-1:0]      alu_ctrl_o,
  input  logic [WIDTH-1:0]       alu_result_i,
  input  logic                   alu_zero_i,
  output logic [1:0]             state_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   win_q, win_idx;
  logic               found;
  logic [NREQ-1:0]    gnt_q, done_q;
  logic [WIDTH-1:0]   result_q, src1_q, src2_q, sel_src1, sel_src2;
  logic [CTRL_W-1:0]  ctrl_q, sel_ctrl;
  logic               zero_q;
  logic [PTR_W-1:0]   ptr_q;

  // Winner search: candidates visited in order ptr, ptr+1, ... with explicit wrap
  // so non-power-of-two NREQ never lands on a nonexistent requester.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      sum = (PTR_W+1)'(i);
`else
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
`endif
      cand = sum[PTR_W-1:0];
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == win_idx) begin
        sel_src1 = src1_i[i*WIDTH +: WIDTH];
        sel_src2 = src2_i[i*WIDTH +: WIDTH];
        sel_ctrl = ctrl_i[i*CTRL_W +: CTRL_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = found ? EXEC : IDLE;
      EXEC:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      if ((state_q == IDLE || state_q == DONE) && found) begin
        win_q  <= win_idx;
        gnt_q  <= NREQ'(1) << win_idx;
        src1_q <= sel_src1;
        src2_q <= sel_src2;
        ctrl_q <= sel_ctrl;
      end else if (state_q == EXEC) begin
        result_q <= alu_result_i;
        zero_q   <= alu_zero_i;
        done_q   <= NREQ'(1) << win_q;
      end
    end
  end

`ifdef ALU_ARB_FIXED_PRI_EN
  assign ptr_q = '0;
`else
  // Pointer advances only on completion, so a waiting requester keeps its place.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (state_q == EXEC) begin
      if (win_q == PTR_W'(NREQ-1)) ptr_q <= '0;
      else                         ptr_q <= win_q + PTR_W'(1);
    end
  end
`endif

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign busy_o     = (state_q == EXEC);
  assign alu_src1_o = src1_q;
  assign alu_src2_o = src2_q;
  assign alu_ctrl_o = ctrl_q;
  assign state_o    = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing one 32-bit ALU among NREQ requesters (e.g. PC adder, branch-target adder, address generator). It accepts a request, presents the winner's latched operands and control code to the external ALU for one cycle, then registers the result and returns it with a one-cycle done pulse to the winning requester. It sits between the datapath requesters and a single ALU instance whose ports are combinational (src1, src2, ctrl in; result, zero out).

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 32: operand/result width
- CTRL_W, 4: ALU control code width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NREQ  per-requester request, bit k = requester k
- src1_i  in  NREQ*WIDTH  flattened operand 1, requester k at [k*WIDTH +: WIDTH]
- src2_i  in  NREQ*WIDTH  flattened operand 2, same packing
- ctrl_i  in  NREQ*CTRL_W  flattened ALU control, requester k at [k*CTRL_W +: CTRL_W]
- gnt_o  out  NREQ  one-hot grant, one-cycle pulse
- done_o  out  NREQ  one-hot completion, one-cycle pulse
- result_o  out  WIDTH  registered ALU result of last completed op
- zero_o  out  1  registered ALU zero flag of last completed op
- busy_o  out  1  high while state is EXEC
- alu_src1_o  out  WIDTH  to ALU operand 1
- alu_src2_o  out  WIDTH  to ALU operand 2
- alu_ctrl_o  out  CTRL_W  to ALU control
- alu_result_i  in  WIDTH  from ALU result
- alu_zero_i  in  1  from ALU zero flag

## Operation
- States: IDLE, EXEC, DONE. Reset -> IDLE.
- IDLE / DONE (arbitrating states): if any req_i bit set, choose winner w by round-robin search starting at pointer ptr (ptr, ptr+1, ... wrapping mod NREQ); latch src1/src2/ctrl of w into operand registers; gnt_o <= onehot(w); state -> EXEC. If no request, -> IDLE.
- EXEC: alu_*_o show latched operands; gnt_o is high this cycle only. At end of cycle: result_o <= alu_result_i, zero_o <= alu_zero_i, done_o <= onehot(w), ptr <= (w+1) mod NREQ, state -> DONE.
- DONE: done_o high this cycle only; arbitrates exactly as IDLE (back-to-back issue allowed).
- alu_*_o are driven from the operand registers at all times; they change only on a new grant.
- Requester handshake: hold req_i and operands stable until gnt_o observed; deassert req_i by the next edge unless another op is wanted. A req_i still high in DONE is a new request.
- Requests arriving while in EXEC are ignored until DONE.
- ptr changes only on completion; a requester not granted keeps its place.
- NREQ not power of two: wrap is explicit compare, not bit truncation.

## Timing
- Reset values: state IDLE, ptr 0, gnt_o 0, done_o 0, busy_o 0, result_o 0, zero_o 0, alu_src1_o 0, alu_src2_o 0, alu_ctrl_o 0.
- Request seen at edge N (IDLE) -> gnt_o and busy_o high cycle N+1 -> done_o and valid result_o cycle N+2.
- Latency 2 cycles request-to-done; throughput one op per 2 cycles under continuous load.
- result_o/zero_o hold until the next completion.
- Reset asserted during EXEC or DONE: return to IDLE next edge, no done_o issued, all outputs to reset values.
- Only one bit of gnt_o and of done_o may be high at any cycle; gnt_o and done_o never high in the same cycle.

## Configuration
- ALU_ARB_FIXED_PRI_EN defined: fixed priority, lowest-index asserted request always wins; ptr register is not implemented (or held at 0); starvation of high indices possible and accepted.
- Undefined (default): round-robin as described above.

## Test plan
- Single request: req_i=0001, src1=5, src2=7, ctrl=2 (add), ALU model adds -> gnt_o=0001 at N+1, done_o=0001 and result_o=12, zero_o=0 at N+2.
- Zero flag: requester 2 issues 9 minus 9 (ctrl=6) -> result_o=0, zero_o=1, done_o=0100.
- All four requesting continuously from reset -> grant order 0,1,2,3,0,... each done 2 cycles apart; with ALU_ARB_FIXED_PRI_EN -> requester 0 granted every time.
- Pointer wrap: grant requester 3, then req_i=1001 -> next grant requester 0, then requester 3.
- Reset mid-op: rst_i high in EXEC cycle -> no done_o, result_o=0, state IDLE; subsequent req_i=0010 completes normally with ptr starting at 0.
- Idle stability: no requests for 20 cycles after an op -> alu_*_o, result_o, zero_o unchanged, gnt_o/done_o/busy_o remain 0.
